// File: rtl/pc_gen.sv
// Fetch program counter: valid/ready handshake, redirect, stall and debug reset.
// Optional return-address stack is compiled in when PC_GEN_RAS_EN is defined.
module pc_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}},
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              hold_i,
  input  logic              fetch_ready_i,
  output logic              fetch_valid_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  output logic              epoch_o,
  input  logic              ras_push_i,
  input  logic [ADDR_W-1:0] ras_push_addr_i,
  input  logic              ras_pop_i,
  output logic              ras_empty_o
);

  localparam int unsigned       ALIGN_W    = $clog2(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_W;
  localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

  logic              w_any_rst;
  logic              r_in_reset;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              r_epoch;
  logic              w_pop_ok;
  logic [ADDR_W-1:0] w_ras_top;

  assign w_any_rst     = rst | jtag_reset_i;
  assign fetch_valid_o = ~hold_i & ~r_in_reset;
  assign fetch_addr_o  = r_pc;
  assign epoch_o       = r_epoch;

  // Reset-tracking flop: masks the request for one cycle after any reset source.
  always_ff @(posedge clk) begin
    r_in_reset <= w_any_rst;
  end

  // Next-PC selection; redirect and RAS pop win over a stall.
  always_comb begin
    w_pc_next = r_pc;
    if (w_any_rst) begin
      w_pc_next = RESET_ADDR;
    end else if (redirect_i) begin
      w_pc_next = redirect_addr_i & ALIGN_MASK;
    end else if (w_pop_ok) begin
      w_pc_next = w_ras_top & ALIGN_MASK;
    end else if (hold_i) begin
      w_pc_next = r_pc;
    end else if (fetch_valid_o & fetch_ready_i) begin
      w_pc_next = r_pc + STEP_INC;
    end else begin
      w_pc_next = r_pc;
    end
  end

  // PC and epoch registers.
  always_ff @(posedge clk) begin
    r_pc <= w_pc_next;
    if (w_any_rst) begin
      r_epoch <= 1'b0;
    end else if (redirect_i) begin
      r_epoch <= ~r_epoch;
    end else begin
      r_epoch <= r_epoch;
    end
  end

`ifdef PC_GEN_RAS_EN
  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [PTR_W:0]    r_cnt;
  logic              w_ras_live;
  logic              w_push;

  // Reset and redirect both suppress any stack activity in that cycle.
  assign w_ras_live  = ~w_any_rst & ~redirect_i;
  assign w_pop_ok    = ras_pop_i & (r_cnt != CNT_ZERO) & w_ras_live;
  assign w_push      = ras_push_i & w_ras_live;
  assign w_ras_top   = r_ras[r_top];
  assign ras_empty_o = (r_cnt == CNT_ZERO);

  // Top pointer and occupancy; a full push wraps onto the oldest slot.
  always_ff @(posedge clk) begin
    if (w_any_rst) begin
      r_top <= PTR_ZERO;
      r_cnt <= CNT_ZERO;
    end else if (w_push & w_pop_ok) begin
      r_top <= r_top;
      r_cnt <= r_cnt;
    end else if (w_push) begin
      r_top <= r_top + PTR_ONE;
      r_cnt <= (r_cnt == CNT_FULL) ? CNT_FULL : r_cnt + CNT_ONE;
    end else if (w_pop_ok) begin
      r_top <= r_top - PTR_ONE;
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_top <= r_top;
      r_cnt <= r_cnt;
    end
  end

  // Entry storage; push-with-pop replaces the current top in place.
  always_ff @(posedge clk) begin
    if (w_push & w_pop_ok) begin
      r_ras[r_top] <= ras_push_addr_i;
    end else if (w_push) begin
      r_ras[r_top + PTR_ONE] <= ras_push_addr_i;
    end
  end
`else
  logic w_unused;

  assign w_unused    = ^{ras_push_i, ras_push_addr_i, ras_pop_i, 32'(RAS_DEPTH)};
  assign w_pop_ok    = 1'b0;
  assign w_ras_top   = r_pc;
  assign ras_empty_o = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a queue-based reference model; adapts to PC_GEN_RAS_EN.
module tb_pc_gen;

  localparam int unsigned AW    = 32;
  localparam logic [31:0] RA    = 32'h0000_0100;
  localparam int unsigned DEPTH = 4;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, jtag, redirect, hold, ready, push, pop;
  logic [31:0] raddr, paddr;
  logic        fetch_valid, epoch, ras_empty;
  logic [31:0] fetch_addr;

  pc_gen #(.ADDR_W(AW), .RESET_ADDR(RA), .STEP(4), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .jtag_reset_i(jtag),
    .redirect_i(redirect), .redirect_addr_i(raddr),
    .hold_i(hold), .fetch_ready_i(ready),
    .fetch_valid_o(fetch_valid), .fetch_addr_o(fetch_addr), .epoch_o(epoch),
    .ras_push_i(push), .ras_push_addr_i(paddr), .ras_pop_i(pop),
    .ras_empty_o(ras_empty)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc = RA;
  bit          m_epoch = 1'b0;
  bit          m_in_reset = 1'b1;
  logic [31:0] m_ras[$];

  task automatic model_update();
    bit v;
    v = !hold && !m_in_reset;
    if (rst || jtag) begin
      m_pc = RA; m_epoch = 1'b0; m_ras.delete(); m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      if (redirect) begin
        m_pc = raddr & ~32'h3; m_epoch = !m_epoch;
      end else begin
        if (RAS_ON && pop && m_ras.size() > 0) m_pc = m_ras.pop_back() & ~32'h3;
        else if (v && ready) m_pc = m_pc + 32'd4;
        if (RAS_ON && push) begin
          m_ras.push_back(paddr);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; jtag = 1'b0; redirect = 1'b0; hold = 1'b0; ready = 1'b0;
    push = 1'b0; pop = 1'b0; raddr = 32'h0; paddr = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; ready = 1'b1;
    tick(); tick(); #2;
    n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
    n_tests++; if (fetch_addr !== RA) begin n_fail++; $display("FAIL reset_addr: got %h want %h", fetch_addr, RA); end
    n_tests++; if (epoch !== 1'b0) begin n_fail++; $display("FAIL reset_epoch: got %b want 0", epoch); end
    n_tests++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ras_empty: got %b want 1", ras_empty); end
    rst = 1'b0; #1;
    n_tests++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", fetch_valid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #2;
      n_tests++; if (fetch_addr !== RA + 32'(4 * i) || fetch_valid !== 1'b1) begin
        n_fail++; $display("FAIL advance_%0d: got %h/%b want %h/1", i, fetch_addr, fetch_valid, RA + 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset(); tick();
    ready = 1'b1; tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_tests++; if (fetch_addr !== 32'h104 || fetch_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %h/%b want 00000104/1", i, fetch_addr, fetch_valid);
      end
      tick();
    end
    ready = 1'b1; tick(); #2;
    n_tests++; if (fetch_addr !== 32'h108) begin n_fail++; $display("FAIL stall_resume: got %h want 00000108", fetch_addr); end
  endtask

  task automatic test_redirect_hold();
    bit e0;
    e0 = m_epoch;
    hold = 1'b1; ready = 1'b1; redirect = 1'b1; raddr = 32'h2003;
    tick(); redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_tests++; if (fetch_addr !== 32'h2000 || epoch !== !e0 || fetch_valid !== 1'b0) begin
        n_fail++; $display("FAIL redir_hold_%0d: got %h/%b/%b want 00002000/%b/0", i, fetch_addr, epoch, fetch_valid, !e0);
      end
      tick();
    end
    hold = 1'b0; #1;
    n_tests++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL redir_unhold_valid: got %b want 1", fetch_valid); end
    tick(); #2;
    n_tests++; if (fetch_addr !== 32'h2004) begin n_fail++; $display("FAIL redir_advance: got %h want 00002004", fetch_addr); end
  endtask

  task automatic test_wrap();
    hold = 1'b0; ready = 1'b1; redirect = 1'b1; raddr = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0; #2;
    n_tests++; if (fetch_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre: got %h want fffffffc", fetch_addr); end
    tick(); #2;
    n_tests++; if (fetch_addr !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h want 00000000", fetch_addr); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_pop [5];
    logic [31:0] exp;
    exp_pop[0] = 32'h50; exp_pop[1] = 32'h40; exp_pop[2] = 32'h30;
    exp_pop[3] = 32'h20; exp_pop[4] = 32'h20;
    do_reset(); hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; paddr = 32'(16 * (i + 1)); tick();
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      exp = RAS_ON ? exp_pop[i] : RA;
      n_tests++; if (fetch_addr !== exp || fetch_addr !== m_pc) begin
        n_fail++; $display("FAIL ras_pop_%0d: got %h want %h", i, fetch_addr, exp);
      end
    end
    pop = 1'b0;
    n_tests++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ras_drained: got %b want 1", ras_empty); end
    push = 1'b1; paddr = 32'h40; tick();
    paddr = 32'h50; tick();
    paddr = 32'h99; pop = 1'b1; tick(); #2;
    exp = RAS_ON ? 32'h50 : RA;
    n_tests++; if (fetch_addr !== exp) begin n_fail++; $display("FAIL ras_push_pop: got %h want %h", fetch_addr, exp); end
    push = 1'b0; tick(); #2;
    exp = RAS_ON ? 32'h99 : RA;
    n_tests++; if (fetch_addr !== exp) begin n_fail++; $display("FAIL ras_new_top: got %h want %h", fetch_addr, exp); end
    n_tests++; if (ras_empty !== !RAS_ON) begin n_fail++; $display("FAIL ras_one_left: got %b want %b", ras_empty, !RAS_ON); end
    pop = 1'b0;
  endtask

  task automatic test_redirect_pop();
    logic [31:0] exp;
    hold = 1'b1; push = 1'b1; paddr = 32'h70; tick();
    redirect = 1'b1; raddr = 32'h3000; pop = 1'b1; paddr = 32'h1234; tick();
    redirect = 1'b0; pop = 1'b0; push = 1'b0; #2;
    n_tests++; if (fetch_addr !== 32'h3000) begin n_fail++; $display("FAIL redir_vs_pop: got %h want 00003000", fetch_addr); end
    pop = 1'b1; tick(); pop = 1'b0; #2;
    exp = RAS_ON ? 32'h70 : 32'h3000;
    n_tests++; if (fetch_addr !== exp) begin n_fail++; $display("FAIL redir_ras_kept: got %h want %h", fetch_addr, exp); end
    hold = 1'b0; ready = 1'b1; push = 1'b1; paddr = 32'h88; jtag = 1'b1;
    tick(); jtag = 1'b0; push = 1'b0; #2;
    n_tests++; if (fetch_addr !== RA || ras_empty !== 1'b1 || fetch_valid !== 1'b0 || epoch !== 1'b0) begin
      n_fail++; $display("FAIL jtag_reset: got %h/%b/%b/%b want %h/1/0/0", fetch_addr, ras_empty, fetch_valid, epoch, RA);
    end
    pop = 1'b1; tick(); pop = 1'b0; #2;
    n_tests++; if (fetch_addr !== RA) begin n_fail++; $display("FAIL jtag_pop_empty: got %h want %h", fetch_addr, RA); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      jtag     = ($urandom_range(0, 49) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      hold     = ($urandom_range(0, 3) == 0);
      ready    = ($urandom_range(0, 1) == 1);
      push     = ($urandom_range(0, 4) == 0);
      pop      = ($urandom_range(0, 5) == 0);
      raddr    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      paddr    = $urandom;
      #2;
      n_tests++; if (fetch_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr_%0d: got %h want %h", i, fetch_addr, m_pc); end
      n_tests++; if (fetch_valid !== (!hold && !m_in_reset)) begin
        n_fail++; $display("FAIL rnd_valid_%0d: got %b want %b", i, fetch_valid, !hold && !m_in_reset);
      end
      n_tests++; if (epoch !== m_epoch) begin n_fail++; $display("FAIL rnd_epoch_%0d: got %b want %b", i, epoch, m_epoch); end
      n_tests++; if (ras_empty !== (m_ras.size() == 0)) begin
        n_fail++; $display("FAIL rnd_ras_empty_%0d: got %b want %b", i, ras_empty, m_ras.size() == 0);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_stall();
    test_redirect_hold();
    test_wrap();
    test_ras();
    test_redirect_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the core fetch stage. It produces the fetch address under a valid/ready handshake and applies redirects (jump/flush), stall and JTAG reset. An optional return-address stack (RAS) supplies predicted return targets. Its output feeds the instruction-bus request path, and it replaces the fixed 32-bit, always-advancing PC register.

## Interface
- ADDR_W, 32: PC width in bits.
- RESET_ADDR, 32'h0: PC value after reset; truncated to ADDR_W.
- STEP, 4: increment per accepted fetch; power of two, 2 or 4.
- RAS_DEPTH, 4: RAS entries; power of two, 2..16; unused without the RAS.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- jtag_reset_i  in  1  debug reset; identical effect to rst.
- redirect_i  in  1  jump/flush from execute.
- redirect_addr_i  in  ADDR_W  redirect target.
- hold_i  in  1  stall PC (pipeline hold at PC level or higher).
- fetch_ready_i  in  1  instruction bus accepts request.
- fetch_valid_o  out  1  request valid.
- fetch_addr_o  out  ADDR_W  request address (current PC).
- epoch_o  out  1  fetch epoch; toggles on every redirect.
- ras_push_i  in  1  predecoded call; push ras_push_addr_i.
- ras_push_addr_i  in  ADDR_W  return address to push.
- ras_pop_i  in  1  predecoded return; jump to RAS top.
- ras_empty_o  out  1  RAS holds no valid entry.

## Operation
- The PC register drives fetch_addr_o. Its low log2(STEP) bits are always zero; redirect and RAS targets are masked to that alignment.
- fetch_valid_o = ~hold_i & ~in_reset. in_reset is a flop set by rst or jtag_reset_i and cleared on the first cycle both are low.
- Next-PC priority, highest first:
  1. rst or jtag_reset_i: PC=RESET_ADDR, epoch=0, RAS cleared.
  2. redirect_i: PC=redirect_addr_i, epoch toggles, RAS pops/pushes ignored that cycle.
  3. ras_pop_i with RAS non-empty: PC=RAS top, entry popped.
  4. hold_i: PC unchanged.
  5. fetch_valid_o & fetch_ready_i: PC=PC+STEP, wrapping modulo 2^ADDR_W.
  6. Otherwise PC unchanged.
- redirect_i and ras_pop_i override hold_i: the PC updates even while stalled.
- ras_pop_i on an empty RAS is ignored; the PC follows rules 4-6.
- RAS is circular, with pointer and count registers.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Push and pop in the same cycle: PC takes the old top, the top is replaced by ras_push_addr_i, count unchanged.
  - A push alone is independent of the PC update.

## Timing
- Reset values: fetch_addr_o=RESET_ADDR, fetch_valid_o=0, epoch_o=0, ras_empty_o=1.
- fetch_valid_o rises in the first cycle after rst/jtag_reset_i deassert.
- Redirect latency: redirect_i in cycle N gives fetch_addr_o=target and a toggled epoch_o in cycle N+1.
- RAS pop latency: the predicted target appears on fetch_addr_o in cycle N+1.
- Handshake: the address is held stable while fetch_valid_o & ~fetch_ready_i. fetch_valid_o drops combinationally with hold_i; that is the only way it drops without a handshake.
- Reset mid-operation: takes effect next edge regardless of other inputs; in-flight RAS contents are discarded.
- No combinational path from fetch_ready_i to fetch_valid_o.

## Configuration
- PC_GEN_RAS_EN defined: RAS storage and pop/push logic are present as described.
- PC_GEN_RAS_EN undefined: no RAS storage; ras_push_i, ras_push_addr_i and ras_pop_i are ignored; ras_empty_o is tied 1; priority reduces to reset > redirect > hold > advance.

## Test plan
- Reset release, fetch_ready_i=1 for 4 cycles with ADDR_W=32, RESET_ADDR=0x100, STEP=4 -> addresses 0x100, 0x104, 0x108, 0x10C; fetch_valid_o=0 during reset.
- fetch_ready_i low for 3 cycles at 0x104 -> address held at 0x104 with fetch_valid_o=1; advances to 0x108 after ready returns.
- redirect_i with hold_i=1, target 0x2003 -> next cycle fetch_addr_o=0x2000, epoch_o toggled, fetch_valid_o=0 until hold_i drops.
- Wrap: PC=0xFFFFFFFC, accept -> 0x00000000.
- RAS (macro on, depth 4):
  - Push 0x10, 0x20, 0x30, 0x40, 0x50, then 5 pops -> targets 0x50, 0x40, 0x30, 0x20; 5th pop ignored; ras_empty_o=1.
  - Simultaneous push 0x99 and pop with top 0x50 -> PC=0x50, new top 0x99.
- Redirect with ras_pop_i in the same cycle -> redirect target wins, RAS count unchanged. jtag_reset_i mid-stream -> PC=RESET_ADDR, RAS empty.
